fm_discriminator: RTL and testbench

//   Parametrised cross-product FM discriminator, successor to the 8-bit demodulator.
//   Per accepted I/Q sample n: d[n] = I[n]*Q[n-1] - Q[n]*I[n-1] (signed).

---
 rtl/fm_discriminator.sv | 114 +++++++++++
 tb/tb_fm_discriminator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fm_discriminator.sv
// Cross-product FM discriminator: d[n] = I[n]*Q[n-1] - Q[n]*I[n-1],
// pipelined, with optional power-of-two integrate-and-dump decimation.
module fm_discriminator #(
    parameter int DW       = 8,
    parameter int AVG_LOG2 = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] I,
    input  logic signed [DW-1:0] Q,
    output logic                 out_valid,
    output logic signed [2*DW:0] m
);
    localparam int PW = 2 * DW;
    localparam int OW = 2 * DW + 1;

    logic signed [DW-1:0] i_last;
    logic signed [DW-1:0] q_last;
    logic                 have_prev;
    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] p2;
    logic                 v1;
    logic signed [OW-1:0] d;
    logic                 v2;

    // History and product stage; clr drops any sample presented with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_last    <= '0;
            q_last    <= '0;
            have_prev <= 1'b0;
            p1        <= '0;
            p2        <= '0;
            v1        <= 1'b0;
        end else if (clr) begin
            i_last    <= '0;
            q_last    <= '0;
            have_prev <= 1'b0;
            v1        <= 1'b0;
        end else begin
            v1 <= in_valid & have_prev;
            if (in_valid) begin
                p1        <= PW'(I) * PW'(q_last);
                p2        <= PW'(Q) * PW'(i_last);
                i_last    <= I;
                q_last    <= Q;
                have_prev <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d  <= '0;
            v2 <= 1'b0;
        end else if (clr) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) d <= OW'(p1) - OW'(p2);
        end
    end

    if (AVG_LOG2 == 0) begin : g_pass
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                m         <= '0;
                out_valid <= 1'b0;
            end else if (clr) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= v2;
                if (v2) m <= d;
            end
        end
    end else begin : g_avg
        localparam int AW = OW + AVG_LOG2;

        logic signed [AW-1:0]       acc;
        logic signed [AW-1:0]       sum;
        logic        [AVG_LOG2-1:0] cnt;

        assign sum = acc + AW'(d);

        // Dropping the low bits of a signed sum floors toward -inf
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc       <= '0;
                cnt       <= '0;
                m         <= '0;
                out_valid <= 1'b0;
            end else if (clr) begin
                acc       <= '0;
                cnt       <= '0;
                out_valid <= 1'b0;
            end else if (v2) begin
                if (&cnt) begin
                    m         <= sum[AW-1:AVG_LOG2];
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc       <= sum;
                    cnt       <= cnt + 1'b1;
                    out_valid <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fm_discriminator.sv
// Bench for fm_discriminator: pass-through and 4x-averaging instances
// driven in parallel and compared against a queue-based reference model.
module tb_fm_discriminator;
    logic              clk;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic signed [7:0] I;
    logic signed [7:0] Q;
    logic              ov0;
    logic              ov2;
    logic signed [16:0] m0;
    logic signed [16:0] m2;

    fm_discriminator #(.DW(8), .AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .I(I), .Q(Q), .out_valid(ov0), .m(m0)
    );

    fm_discriminator #(.DW(8), .AVG_LOG2(2)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .I(I), .Q(Q), .out_valid(ov2), .m(m2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int     due;
        longint val;
    } ev_t;

    ev_t    pend0[$];
    ev_t    pend2[$];
    longint win[$];
    int     vectors = 0;
    int     errors  = 0;
    int     cyc     = 0;
    int     il      = 0;
    int     ql      = 0;
    bit     have    = 0;
    longint mh0     = 0;
    longint mh2     = 0;
    int     strobes_obs = 0;
    int     strobes_exp = 0;

    task automatic chk(string tag, longint got, longint exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        pend0.delete();
        pend2.delete();
        win.delete();
        have = 0;
        il = 0;
        ql = 0;
    endtask

    // Reference: d from previous accepted sample; result due 2 edges later
    task automatic model_edge(bit v, bit c, int i, int q);
        longint d;
        longint s;
        if (!rst || c) begin
            model_clear();
        end else if (v) begin
            if (have) begin
                d = longint'(i) * ql - longint'(q) * il;
                pend0.push_back('{cyc + 2, d});
                win.push_back(d);
                if (win.size() == 4) begin
                    s = 0;
                    foreach (win[k]) s += win[k];
                    pend2.push_back('{cyc + 2, s >>> 2});
                    win.delete();
                end
            end
            il = i;
            ql = q;
            have = 1;
        end
    endtask

    task automatic compare();
        bit e0;
        bit e2;
        e0 = (pend0.size() > 0) && (pend0[0].due == cyc);
        e2 = (pend2.size() > 0) && (pend2[0].due == cyc);
        if (e0) begin
            mh0 = pend0[0].val;
            void'(pend0.pop_front());
            strobes_exp++;
        end
        if (e2) begin
            mh2 = pend2[0].val;
            void'(pend2.pop_front());
        end
        if (ov0) strobes_obs++;
        chk("ov0", ov0, e0);
        chk("m0", m0, mh0);
        chk("ov2", ov2, e2);
        chk("m2", m2, mh2);
    endtask

    task automatic step(bit v, bit c, int i, int q);
        in_valid = v;
        clr = c;
        I = 8'(i);
        Q = 8'(q);
        @(posedge clk);
        cyc++;
        model_edge(v, c, i, q);
        #1;
        compare();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        I = '0;
        Q = '0;
        #2;
        chk("rst_ov0", ov0, 0);
        chk("rst_m0", m0, 0);
        chk("rst_ov2", ov2, 0);
        chk("rst_m2", m2, 0);
        #10 rst = 1'b1;

        // Quadrature step: one result, three edges after second sample
        step(1, 0, 100, 0);
        step(1, 0, 0, 100);
        idle(3);
        chk("t1_m", m0, -10000);
        chk("t1_cnt", strobes_obs, 1);

        // Extremes for sign extension
        step(1, 1, 0, 0);
        step(1, 0, -128, -128);
        step(1, 0, -128, 127);
        idle(3);
        chk("t2_max", m0, 32640);
        step(1, 0, 127, -128);
        step(1, 0, -128, 127);
        idle(3);

        // Averaging: d = 10,20,30,41 then -1,0,0,0 in a fresh window
        step(0, 1, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 0, -10);
        step(1, 0, -2, 0);
        step(1, 0, 1, 15);
        step(1, 0, 3, 4);
        idle(3);
        chk("t4_avg25", m2, 25);
        step(1, 0, -1, -1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(3);
        chk("t4_avgm1", m2, -1);

        // Async reset between edges, mid-stream
        step(1, 0, 50, -30);
        step(1, 0, -70, 20);
        step(1, 0, 33, 90);
        #2 rst = 1'b0;
        #1;
        chk("t5_ov0", ov0, 0);
        chk("t5_m0", m0, 0);
        chk("t5_m2", m2, 0);
        model_clear();
        mh0 = 0;
        mh2 = 0;
        step(1, 0, 9, 9);
        step(0, 0, 0, 0);
        rst = 1'b1;
        strobes_obs = 0;
        strobes_exp = 0;
        step(1, 0, 12, -5);
        idle(3);
        chk("t5_first", strobes_obs, 0);
        for (int k = 0; k < 6; k++) step(1, 0, 3 * k - 7, 11 - k);
        idle(3);

        // clr with in_valid mid-window
        step(1, 0, 40, 10);
        step(1, 0, -20, 60);
        step(1, 1, 99, 99);
        step(1, 0, 5, 7);
        step(1, 0, -8, 2);
        idle(3);
        for (int k = 0; k < 4; k++) step(1, 0, k + 1, -k);
        idle(3);

        // Random stream, ~50% valid duty, rare clr
        strobes_obs = 0;
        strobes_exp = 0;
        for (int n = 0; n < 10000; n++) begin
            bit v;
            bit c;
            int i;
            int q;
            v = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) begin
                i = $urandom_range(0, 1) ? 127 : -128;
                q = $urandom_range(0, 1) ? 127 : -128;
            end else begin
                i = int'($urandom_range(0, 255)) - 128;
                q = int'($urandom_range(0, 255)) - 128;
            end
            step(v, c, i, q);
        end
        idle(4);
        chk("rand_strobes", strobes_obs, strobes_exp);
        chk("drain0", pend0.size(), 0);
        chk("drain2", pend2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
